// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_ctrl_pkg
//  Description : Shared constants for the RV32I multicycle controller:
//                opcodes, FSM state encoding and datapath select codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_ctrl_pkg;

   // Opcode field values handled by the sequencer
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // Sequencer states, 4-bit encoding
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10,
      S_UPPER    = 4'd11,
      S_ILLEGAL  = 4'd12
   } state_t;

   // ALU operand A select
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   // ALU operand B select
   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   // ALUOp encoding consumed by the ALU decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE = 2'b11;

   // Result bus select
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // Immediate format select
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // Register write data select
   localparam logic [1:0] RDS_RESULT = 2'b00;
   localparam logic [1:0] RDS_AUIPC  = 2'b01;
   localparam logic [1:0] RDS_LUI    = 2'b10;

   // True for the two U-type opcodes
   function automatic logic is_upper_op(input logic [6:0] op);
      return (op == OP_LUI) || (op == OP_AUIPC);
   endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_instrdec.sv
`default_nettype none
// ============================================================================
//  Module      : instrdec
//  Description : Combinational opcode to immediate-format decoder.
//                Optional feature macro: RV_UPPER_IMM_EN (U-type format).
//  Revision    : 1.0 - initial release
// ============================================================================
module instrdec
   import rv_ctrl_pkg::*;
(
   input  logic [6:0] op,
   output logic [2:0] ImmSrc
);

   // Immediate format follows the opcode in every state
   always_comb begin
      ImmSrc = IMM_I;
      case (op)
         OP_LOAD,
         OP_ITYPE:  ImmSrc = IMM_I;
         OP_STORE:  ImmSrc = IMM_S;
         OP_BRANCH: ImmSrc = IMM_B;
         OP_JAL:    ImmSrc = IMM_J;
`ifdef RV_UPPER_IMM_EN
         OP_LUI,
         OP_AUIPC:  ImmSrc = IMM_U;
`endif
         default:   ImmSrc = IMM_I;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Moore sequencer stepping the shared ALU, memory port and
//                register file through fetch/decode/execute/writeback.
//                Memory states stall on MemReady.
//                Optional feature macro: RV_UPPER_IMM_EN (lui/auipc support).
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
   import rv_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] ResultSrc,
   output logic [2:0] ImmSrc,
   output logic       DataExtSrc,
   output logic [1:0] RegDataSrc,
   output logic       IllegalOp,
   output logic       InstrDone
);

   state_t     r_state;
   state_t     w_state_next;
   logic       w_pc_update;
   logic       w_branch;
   logic [1:0] w_reg_data_src;

   // Immediate format is a pure function of the opcode
   instrdec u_instrdec (
      .op     (op),
      .ImmSrc (ImmSrc)
   );

   // State register; reset snaps straight back to FETCH
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state selection
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_FETCH:    w_state_next = MemReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LOAD,
               OP_STORE:  w_state_next = S_MEMADR;
               OP_RTYPE:  w_state_next = S_EXECUTER;
               OP_ITYPE:  w_state_next = S_EXECUTEI;
               OP_JAL:    w_state_next = S_JAL;
               OP_BRANCH: w_state_next = S_BEQ;
`ifdef RV_UPPER_IMM_EN
               OP_LUI,
               OP_AUIPC:  w_state_next = S_UPPER;
`endif
               default:   w_state_next = S_ILLEGAL;
            endcase
         end
         // Only loads and stores reach MEMADR, so anything not a load is a store
         S_MEMADR:   w_state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  w_state_next = MemReady ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    w_state_next = S_FETCH;
         S_MEMWRITE: w_state_next = MemReady ? S_FETCH : S_MEMWRITE;
         S_EXECUTER: w_state_next = S_ALUWB;
         S_EXECUTEI: w_state_next = S_ALUWB;
         S_ALUWB:    w_state_next = S_FETCH;
         S_JAL:      w_state_next = S_ALUWB;
         S_BEQ:      w_state_next = S_FETCH;
         S_UPPER:    w_state_next = S_FETCH;
         S_ILLEGAL:  w_state_next = S_FETCH;
         default:    w_state_next = S_FETCH;
      endcase
   end

   // Moore output decode, with MemReady gating in the memory states and
   // all write/pulse strobes suppressed while reset is held
   always_comb begin
      w_pc_update    = 1'b0;
      w_branch       = 1'b0;
      w_reg_data_src = RDS_RESULT;
      AdrSrc         = 1'b0;
      IRWrite        = 1'b0;
      MemWrite       = 1'b0;
      RegWrite       = 1'b0;
      ALUSrcA        = SRCA_PC;
      ALUSrcB        = SRCB_RS2;
      ALUOp          = ALUOP_ADD;
      ResultSrc      = RES_ALUOUT;
      DataExtSrc     = 1'b0;
      IllegalOp      = 1'b0;
      InstrDone      = 1'b0;
      case (r_state)
         S_FETCH: begin
            AdrSrc      = 1'b0;
            ALUSrcA     = SRCA_PC;
            ALUSrcB     = SRCB_FOUR;
            ResultSrc   = RES_ALURESULT;
            IRWrite     = MemReady;
            w_pc_update = MemReady;
         end
         S_DECODE: begin
            // Branch/jump target is precomputed into ALUOut here
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD: begin
            AdrSrc    = 1'b1;
            ResultSrc = RES_ALUOUT;
         end
         S_MEMWB: begin
            ResultSrc  = RES_DATA;
            RegWrite   = 1'b1;
            DataExtSrc = 1'b1;
            InstrDone  = 1'b1;
         end
         S_MEMWRITE: begin
            // Strobe stays up for the whole access, including the ready cycle
            AdrSrc    = 1'b1;
            ResultSrc = RES_ALUOUT;
            MemWrite  = 1'b1;
            InstrDone = MemReady;
         end
         S_EXECUTER: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_RS2;
            ALUOp   = ALUOP_RTYPE;
         end
         S_EXECUTEI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_ITYPE;
         end
         S_ALUWB: begin
            ResultSrc = RES_ALUOUT;
            RegWrite  = 1'b1;
            InstrDone = 1'b1;
         end
         S_JAL: begin
            // Return address = OldPC + 4; target already sits in ALUOut
            ALUSrcA     = SRCA_OLDPC;
            ALUSrcB     = SRCB_FOUR;
            ResultSrc   = RES_ALUOUT;
            w_pc_update = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA   = SRCA_RS1;
            ALUSrcB   = SRCB_RS2;
            ALUOp     = ALUOP_SUB;
            ResultSrc = RES_ALUOUT;
            w_branch  = 1'b1;
            InstrDone = 1'b1;
         end
`ifdef RV_UPPER_IMM_EN
         S_UPPER: begin
            RegWrite       = 1'b1;
            w_reg_data_src = (op == OP_LUI) ? RDS_LUI : RDS_AUIPC;
            InstrDone      = 1'b1;
         end
`endif
         S_ILLEGAL: begin
            IllegalOp = 1'b1;
         end
         default: begin
            IllegalOp = 1'b0;
         end
      endcase
      if (reset) begin
         w_pc_update = 1'b0;
         w_branch    = 1'b0;
         IRWrite     = 1'b0;
         MemWrite    = 1'b0;
         RegWrite    = 1'b0;
         IllegalOp   = 1'b0;
         InstrDone   = 1'b0;
      end
   end

   // Upper-immediate path select exists only with the U-type feature
`ifdef RV_UPPER_IMM_EN
   assign RegDataSrc = w_reg_data_src;
`else
   assign RegDataSrc = RDS_RESULT;
`endif

   assign PCWrite = w_pc_update | (w_branch & Zero);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Directed, table-driven bench for multicycle_ctrl with
//                hand-written reset-during-store sequence.
//                Honours RV_UPPER_IMM_EN for the lui/auipc expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

   localparam logic [6:0] C_LOAD  = 7'b0000011;
   localparam logic [6:0] C_STORE = 7'b0100011;
   localparam logic [6:0] C_R     = 7'b0110011;
   localparam logic [6:0] C_I     = 7'b0010011;
   localparam logic [6:0] C_JAL   = 7'b1101111;
   localparam logic [6:0] C_BEQ   = 7'b1100011;
   localparam logic [6:0] C_LUI   = 7'b0110111;
   localparam logic [6:0] C_AUIPC = 7'b0010111;
   localparam logic [6:0] C_BAD   = 7'b1111111;

`ifdef RV_UPPER_IMM_EN
   localparam logic [2:0] C_IMM_U = 3'b100;
`else
   localparam logic [2:0] C_IMM_U = 3'b000;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic       Zero;
   logic       MemReady;
   logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
   logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
   logic [2:0] ImmSrc;
   logic       DataExtSrc;
   logic [1:0] RegDataSrc;
   logic       IllegalOp, InstrDone;

   int passed = 0;
   int total  = 0;

   multicycle_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .Zero       (Zero),
      .MemReady   (MemReady),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .IRWrite    (IRWrite),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ALUOp      (ALUOp),
      .ResultSrc  (ResultSrc),
      .ImmSrc     (ImmSrc),
      .DataExtSrc (DataExtSrc),
      .RegDataSrc (RegDataSrc),
      .IllegalOp  (IllegalOp),
      .InstrDone  (InstrDone)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [6:0]  op;
      logic        zero;
      logic        mr;
      logic [20:0] exp;
   } vec_t;

   vec_t vecs[$];

   // Expected output word: {PCWrite,AdrSrc,IRWrite,MemWrite,RegWrite,
   //  ALUSrcA,ALUSrcB,ALUOp,ResultSrc,ImmSrc,DataExtSrc,RegDataSrc,IllegalOp,InstrDone}
   function automatic logic [20:0] E(input logic pcw, input logic adr, input logic irw,
                                     input logic mw, input logic rw, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] aop,
                                     input logic [1:0] rs, input logic [2:0] imm,
                                     input logic dx, input logic [1:0] rds,
                                     input logic ill, input logic dn);
      return {pcw, adr, irw, mw, rw, sa, sb, aop, rs, imm, dx, rds, ill, dn};
   endfunction

   function automatic logic [20:0] fetch_e(input logic [2:0] imm, input logic mr);
      return E(mr, 1'b0, mr, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, imm, 1'b0, 2'b00, 1'b0, 1'b0);
   endfunction

   function automatic logic [20:0] decode_e(input logic [2:0] imm);
      return E(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, imm, 1'b0, 2'b00, 1'b0, 1'b0);
   endfunction

   task automatic add(input logic r, input logic [6:0] o, input logic z, input logic m,
                      input logic [20:0] e);
      vec_t v;
      v.rst = r; v.op = o; v.zero = z; v.mr = m; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic check(input string nm, input logic [20:0] exp);
      logic [20:0] act;
      act = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
             ResultSrc, ImmSrc, DataExtSrc, RegDataSrc, IllegalOp, InstrDone};
      total++;
      if (act !== exp)
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      else
         passed++;
   endtask

   // One clock: drive inputs just after the edge, sample shortly before the next
   task automatic step(input logic r, input logic [6:0] o, input logic z, input logic m);
      @(posedge clk);
      #1;
      reset = r; op = o; Zero = z; MemReady = m;
      #3;
   endtask

   initial begin
      reset = 1'b1; op = C_R; Zero = 1'b0; MemReady = 1'b1;

      // reset: FETCH selects, all strobes forced low
      add(1, C_R, 0, 1, fetch_e(3'b000, 1'b0));
      // R-type: 4 cycles, Zero=1 must not leak into PCWrite
      add(0, C_R, 0, 1, fetch_e(3'b000, 1'b1));
      add(0, C_R, 1, 1, decode_e(3'b000));
      add(0, C_R, 1, 1, E(0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,2'b00,0,0));
      add(0, C_R, 1, 1, E(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,2'b00,0,1));
      // I-type with MemReady low in non-memory states (ignored)
      add(0, C_I, 0, 1, fetch_e(3'b000, 1'b1));
      add(0, C_I, 0, 0, decode_e(3'b000));
      add(0, C_I, 0, 0, E(0,0,0,0,0, 2'b10,2'b01,2'b11,2'b00, 3'b000, 0,2'b00,0,0));
      add(0, C_I, 0, 1, E(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,2'b00,0,1));
      // load, MEMREAD stalls two cycles: 7 cycles total
      add(0, C_LOAD, 0, 1, fetch_e(3'b000, 1'b1));
      add(0, C_LOAD, 0, 1, decode_e(3'b000));
      add(0, C_LOAD, 0, 1, E(0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 3'b000, 0,2'b00,0,0));
      add(0, C_LOAD, 0, 0, E(0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,2'b00,0,0));
      add(0, C_LOAD, 0, 0, E(0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,2'b00,0,0));
      add(0, C_LOAD, 0, 1, E(0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,2'b00,0,0));
      add(0, C_LOAD, 0, 1, E(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b01, 3'b000, 1,2'b00,0,1));
      // store, MemReady low three cycles: MemWrite held four cycles
      add(0, C_STORE, 0, 1, fetch_e(3'b001, 1'b1));
      add(0, C_STORE, 0, 1, decode_e(3'b001));
      add(0, C_STORE, 0, 1, E(0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 3'b001, 0,2'b00,0,0));
      add(0, C_STORE, 0, 0, E(0,1,0,1,0, 2'b00,2'b00,2'b00,2'b00, 3'b001, 0,2'b00,0,0));
      add(0, C_STORE, 0, 0, E(0,1,0,1,0, 2'b00,2'b00,2'b00,2'b00, 3'b001, 0,2'b00,0,0));
      add(0, C_STORE, 0, 0, E(0,1,0,1,0, 2'b00,2'b00,2'b00,2'b00, 3'b001, 0,2'b00,0,0));
      add(0, C_STORE, 0, 1, E(0,1,0,1,0, 2'b00,2'b00,2'b00,2'b00, 3'b001, 0,2'b00,0,1));
      // beq taken, with a fetch stall first
      add(0, C_BEQ, 0, 0, fetch_e(3'b010, 1'b0));
      add(0, C_BEQ, 0, 1, fetch_e(3'b010, 1'b1));
      add(0, C_BEQ, 1, 1, decode_e(3'b010));
      add(0, C_BEQ, 1, 1, E(1,0,0,0,0, 2'b10,2'b00,2'b01,2'b00, 3'b010, 0,2'b00,0,1));
      // beq not taken
      add(0, C_BEQ, 0, 1, fetch_e(3'b010, 1'b1));
      add(0, C_BEQ, 0, 1, decode_e(3'b010));
      add(0, C_BEQ, 0, 1, E(0,0,0,0,0, 2'b10,2'b00,2'b01,2'b00, 3'b010, 0,2'b00,0,1));
      // jal
      add(0, C_JAL, 0, 1, fetch_e(3'b011, 1'b1));
      add(0, C_JAL, 0, 1, decode_e(3'b011));
      add(0, C_JAL, 0, 1, E(1,0,0,0,0, 2'b01,2'b10,2'b00,2'b00, 3'b011, 0,2'b00,0,0));
      add(0, C_JAL, 0, 1, E(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b011, 0,2'b00,0,1));
      // lui / auipc
      add(0, C_LUI, 0, 1, fetch_e(C_IMM_U, 1'b1));
      add(0, C_LUI, 0, 1, decode_e(C_IMM_U));
`ifdef RV_UPPER_IMM_EN
      add(0, C_LUI, 0, 1, E(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b100, 0,2'b10,0,1));
`else
      add(0, C_LUI, 0, 1, E(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,2'b00,1,0));
`endif
      add(0, C_AUIPC, 0, 1, fetch_e(C_IMM_U, 1'b1));
      add(0, C_AUIPC, 0, 1, decode_e(C_IMM_U));
`ifdef RV_UPPER_IMM_EN
      add(0, C_AUIPC, 0, 1, E(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b100, 0,2'b01,0,1));
`else
      add(0, C_AUIPC, 0, 1, E(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,2'b00,1,0));
`endif
      // unsupported opcode, then back to FETCH (stalled)
      add(0, C_BAD, 0, 1, fetch_e(3'b000, 1'b1));
      add(0, C_BAD, 0, 1, decode_e(3'b000));
      add(0, C_BAD, 0, 1, E(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,2'b00,1,0));
      add(0, C_R,   0, 0, fetch_e(3'b000, 1'b0));

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].op, vecs[i].zero, vecs[i].mr);
         check($sformatf("vec%0d op=%b", i, vecs[i].op), vecs[i].exp);
      end

      // reset asserted in the middle of a stalled store
      step(0, C_STORE, 0, 1);
      check("rst_seq fetch", fetch_e(3'b001, 1'b1));
      step(0, C_STORE, 0, 1);
      check("rst_seq decode", decode_e(3'b001));
      step(0, C_STORE, 0, 1);
      check("rst_seq memadr", E(0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 3'b001, 0,2'b00,0,0));
      step(0, C_STORE, 0, 0);
      check("rst_seq memwrite", E(0,1,0,1,0, 2'b00,2'b00,2'b00,2'b00, 3'b001, 0,2'b00,0,0));
      #1;
      reset = 1'b1;
      #1;
      check("rst_seq async drop", fetch_e(3'b001, 1'b0));
      step(1, C_STORE, 0, 1);
      check("rst_seq held", fetch_e(3'b001, 1'b0));
      step(0, C_STORE, 0, 1);
      check("rst_seq release fetch", fetch_e(3'b001, 1'b1));
      step(0, C_STORE, 0, 1);
      check("rst_seq release decode", decode_e(3'b001));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle sequencer for the RV32I core. Replaces the single-cycle decode with a Moore FSM that steps the shared ALU, memory port and register file through fetch/decode/execute/writeback over several cycles. It also holds off the memory port until the memory signals `MemReady`. It sits in the controller beside the ALU decoder, which consumes `ALUOp`.

## Interface
- No parameters.
- `clk` in 1: core clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `op` in 7: opcode field of the instruction register.
- `Zero` in 1: ALU zero flag.
- `MemReady` in 1: memory access completes this cycle.
- `PCWrite` out 1: `PCUpdate | (Branch & Zero)`.
- `AdrSrc` out 1: memory address select (0 PC, 1 ALUOut).
- `IRWrite` out 1: load instruction/old-PC registers.
- `MemWrite` out 1: store strobe.
- `RegWrite` out 1: register file write.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 rs1.
- `ALUSrcB` out 2: 00 rs2, 01 ImmExt, 10 constant 4.
- `ALUOp` out 2: 00 add, 01 sub/branch, 10 R-type, 11 I-type.
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `ImmSrc` out 3: 000 I, 001 S, 010 B, 011 J, 100 U.
- `DataExtSrc` out 1: 0 store path, 1 load path.
- `RegDataSrc` out 2: 00 result, 01 auipc, 10 lui.
- `IllegalOp` out 1: one-cycle pulse on an unsupported opcode.
- `InstrDone` out 1: one-cycle pulse on the last cycle of each instruction.

## Operation
- Moore FSM. Outputs decode from state only, except gating by `MemReady` where stated. Unlisted outputs are 0.
- FETCH:
  - Outputs: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
  - IRWrite and PCUpdate equal `MemReady`.
  - Stays in FETCH while `!MemReady`, else goes to DECODE.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01 (target into ALUOut).
  - Next state by op: 0000011 or 0100011 → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1101111 → JAL; 1100011 → BEQ; 0110111 or 0010111 → UPPER (macro); anything else → ILLEGAL.
- MEMADR:
  - Outputs: ALUSrcA=10, ALUSrcB=01.
  - Next: load → MEMREAD, store → MEMWRITE.
- MEMREAD:
  - Outputs: AdrSrc=1, ResultSrc=00.
  - Waits for `MemReady`, then goes to MEMWB.
- MEMWB:
  - Outputs: ResultSrc=01, RegWrite=1, DataExtSrc=1.
  - Goes to FETCH; InstrDone=1.
- MEMWRITE:
  - Outputs: AdrSrc=1, ResultSrc=00.
  - MemWrite is held at 1 until `MemReady`, then FETCH with InstrDone=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10; goes to ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=11; goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1; goes to FETCH with InstrDone=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate=1; goes to ALUWB.
- BEQ:
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - Goes to FETCH with InstrDone=1.
- UPPER: RegWrite=1, RegDataSrc=10 for lui or 01 for auipc; goes to FETCH with InstrDone=1.
- ILLEGAL: IllegalOp=1, no writes; goes to FETCH.
- ImmSrc is combinational from `op` in every state: load/op-imm 000, store 001, branch 010, jal 011, lui/auipc 100, else 000.

## Timing
- Reset:
  - State goes to FETCH immediately on `reset` assertion.
  - While `reset`=1, IRWrite, PCUpdate, PCWrite, MemWrite, RegWrite, IllegalOp and InstrDone are forced to 0. Other outputs take their FETCH values.
  - Reset asserted mid-access drops MemWrite in the same cycle.
- Cycles per instruction with `MemReady` always 1:
  - R, I, jal: 4.
  - beq: 3.
  - load: 5.
  - store: 4.
  - lui/auipc: 3.
- Each cycle of `MemReady`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs stay stable during the stall.
- `MemReady` is ignored in all other states.

## Configuration
- `RV_UPPER_IMM_EN` defined: UPPER state and U-type ImmSrc are present.
- `RV_UPPER_IMM_EN` undefined: lui and auipc decode to ILLEGAL, and RegDataSrc is constant 00.

## Structure
- Package `rv_ctrl_pkg` holds:
  - opcode constants;
  - the state enum (4-bit);
  - the ALUSrcA/B, ResultSrc, ImmSrc and RegDataSrc select constants.
- Sub-module `instrdec`: combinational op → ImmSrc.

## Test plan
- Reset, then op=0110011 with `MemReady`=1 → FETCH, DECODE, EXECUTER, ALUWB; RegWrite=1 and ALUOp=10 in cycle 4; InstrDone pulses once.
- Load with `MemReady` low for 2 cycles in MEMREAD → 7 cycles total; RegWrite=1 with DataExtSrc=1 in MEMWB only.
- Store with `MemReady`=0 for 3 cycles → MemWrite held 4 cycles, falls after `MemReady`; RegWrite stays 0.
- BEQ with Zero=1 → PCWrite=1 in cycle 3; repeat with Zero=0 → PCWrite stays 0.
- op=0110111:
  - with `RV_UPPER_IMM_EN` → RegDataSrc=10 and ImmSrc=100;
  - without it → IllegalOp pulses in cycle 3 and there are no writes.
- Assert `reset` during MEMWRITE → MemWrite=0 in the same cycle; after release the FSM is in FETCH.
